// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader.
// Takes decoded fields (format, opcode, funct3, funct7 bit 30, registers,
// immediate), builds the 32-bit instruction word, and writes it to
// instruction memory at an auto-incrementing word address.
// Optional macro ENC_RANGE_CHECK_EN: when defined, immediates are checked for
// range (error code 2) and alignment (error code 3). When undefined,
// immediates are truncated to their field bits, and only illegal-format errors
// (code 1) are reported.
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            fmt_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = {ADDR_WIDTH{1'b1}};

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                state_q;
  logic [2:0]            fmt_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic                  f7b5_q;
  logic [4:0]            rd_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [31:0]           imm_q;
  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [31:0]           wdata_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  full_q;
  logic                  err_q;
  logic [1:0]            err_code_q;

  logic [31:0]           enc_word_d;
  logic [1:0]            enc_code_d;
  logic                  is_shift_d;

`ifdef ENC_RANGE_CHECK_EN
  logic                  imm12_ok;
  logic                  imm13_ok;
  logic                  imm21_ok;

  // Signed range windows for the I/S, B and J immediates.
  assign imm12_ok = ($signed(imm_q) >= -32'sd2048)    && ($signed(imm_q) <= 32'sd2047);
  assign imm13_ok = ($signed(imm_q) >= -32'sd4096)    && ($signed(imm_q) <= 32'sd4094);
  assign imm21_ok = ($signed(imm_q) >= -32'sd1048576) && ($signed(imm_q) <= 32'sd1048574);
`endif

  // Build the instruction word and classify errors from the captured fields.
  always_comb begin
    enc_word_d = '0;
    enc_code_d = ERR_NONE;
    is_shift_d = (funct3_q == 3'd1) || (funct3_q == 3'd5);
    case (fmt_q)
      FMT_R: enc_word_d = {1'b0, f7b5_q, 5'b00000, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
      FMT_I: begin
        if (is_shift_d) begin
          enc_word_d = {1'b0, f7b5_q, 5'b00000, imm_q[4:0], rs1_q, funct3_q, rd_q, opcode_q};
        end else begin
          enc_word_d = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
        end
      end
      FMT_S: enc_word_d = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
      FMT_B: enc_word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                           imm_q[4:1], imm_q[11], opcode_q};
      FMT_U: enc_word_d = {imm_q[31:12], rd_q, opcode_q};
      FMT_J: enc_word_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
      default: enc_code_d = ERR_FMT;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    // Range is tested first so an out-of-range odd offset reports code 2.
    case (fmt_q)
      FMT_I: begin
        if (is_shift_d ? (imm_q > 32'd31) : !imm12_ok) enc_code_d = ERR_RANGE;
      end
      FMT_S: begin
        if (!imm12_ok) enc_code_d = ERR_RANGE;
      end
      FMT_B: begin
        if (!imm13_ok)     enc_code_d = ERR_RANGE;
        else if (imm_q[0]) enc_code_d = ERR_ALIGN;
      end
      FMT_U: begin
        if (imm_q[11:0] != 12'd0) enc_code_d = ERR_ALIGN;
      end
      FMT_J: begin
        if (!imm21_ok)     enc_code_d = ERR_RANGE;
        else if (imm_q[0]) enc_code_d = ERR_ALIGN;
      end
      default: ;
    endcase
`endif
  end

  // Control FSM: accept -> check -> write, with start_i overriding all activity.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fmt_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      f7b5_q     <= 1'b0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      ptr_q      <= BASE_PTR;
      wdata_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (start_i) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      ptr_q      <= BASE_PTR;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            fmt_q    <= fmt_i;
            opcode_q <= opcode_i;
            funct3_q <= funct3_i;
            f7b5_q   <= funct7b5_i;
            rd_q     <= rd_i;
            rs1_q    <= rs1_i;
            rs2_q    <= rs2_i;
            imm_q    <= imm_i;
            ready_q  <= 1'b0;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (enc_code_d != ERR_NONE) begin
            err_q <= 1'b1;
            if (err_code_q == ERR_NONE) err_code_q <= enc_code_d;
            ready_q <= !full_q;
            state_q <= S_IDLE;
          end else begin
            we_q    <= 1'b1;
            wdata_q <= enc_word_d;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          count_q <= count_q + CNT_WIDTH'(1);
          if (ptr_q == LAST_PTR) begin
            full_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            ptr_q   <= ptr_q + ADDR_WIDTH'(1);
            ready_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= !full_q;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = ptr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader (4-word memory so the full condition is reachable).
module tb_instr_encoder_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned CAP = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    fmt_i;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic          funct7b5_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [31:0]   imm_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .count_o(count_o), .full_o(full_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model state.
  int          m_ptr;
  int          m_count;
  bit          m_full;
  bit          m_err;
  int          m_code;
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word and error class computed from the ISA field layout.
  function automatic void model_enc(input int fmt, input int op, input int f3, input int f7,
                                    input int rd, input int rs1, input int rs2,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output int code);
    int signed v;
    int rng;
    v = $signed(imm);
    w = 32'd0;
    code = 0;
    rng = 0;
    case (fmt)
      0: w = op + rd * 32'd128 + f3 * 32'd4096 + rs1 * 32'h8000 + rs2 * 32'h100000
             + f7 * 32'h40000000;
      1: begin
        if (f3 == 1 || f3 == 5) begin
          w = op + rd * 32'd128 + f3 * 32'd4096 + rs1 * 32'h8000
              + (imm % 32) * 32'h100000 + f7 * 32'h40000000;
          if (v < 0 || v > 31) rng = 2;
        end else begin
          w = op + rd * 32'd128 + f3 * 32'd4096 + rs1 * 32'h8000 + (imm % 4096) * 32'h100000;
          if (v < -2048 || v > 2047) rng = 2;
        end
      end
      2: begin
        w = op + (imm % 32) * 32'd128 + f3 * 32'd4096 + rs1 * 32'h8000 + rs2 * 32'h100000
            + ((imm / 32) % 128) * 32'h2000000;
        if (v < -2048 || v > 2047) rng = 2;
      end
      3: begin
        w = op + ((imm / 2048) % 2) * 32'd128 + ((imm / 2) % 16) * 32'd256
            + f3 * 32'd4096 + rs1 * 32'h8000 + rs2 * 32'h100000
            + ((imm / 32) % 64) * 32'h2000000 + ((imm / 4096) % 2) * 32'h80000000;
        if (v < -4096 || v > 4094) rng = 2;
        else if (imm % 2 != 0) rng = 3;
      end
      4: begin
        w = op + rd * 32'd128 + (imm - imm % 4096);
        if (imm % 4096 != 0) rng = 3;
      end
      5: begin
        w = op + rd * 32'd128 + ((imm / 4096) % 256) * 32'h1000
            + ((imm / 2048) % 2) * 32'h100000 + ((imm / 2) % 1024) * 32'h200000
            + ((imm / 1048576) % 2) * 32'h80000000;
        if (v < -1048576 || v > 1048574) rng = 2;
        else if (imm % 2 != 0) rng = 3;
      end
      default: code = 1;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (code == 0) code = rng;
`endif
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_code = 0;
  endfunction

  // Every write strobe must match the next word the model expects.
  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr_o), 32'hFFFF_FFFF);
      end else begin
        chk("write_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
        chk("write_data", mem_wdata_o, exp_data_q.pop_front());
      end
    end
  end

  task automatic chk_state(input string tag);
    chk({tag, "_count"},  32'(count_o),    32'(m_count));
    chk({tag, "_full"},   32'(full_o),     32'(m_full));
    chk({tag, "_err"},    32'(err_o),      32'(m_err));
    chk({tag, "_code"},   32'(err_code_o), 32'(m_code));
    chk({tag, "_ready"},  32'(req_ready_o), 32'(!m_full));
    chk({tag, "_ptr"},    32'(mem_addr_o), 32'(m_ptr));
  endtask

  task automatic drive(input int fmt, input int op, input int f3, input int f7,
                       input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    fmt_i = 3'(fmt); opcode_i = 7'(op); funct3_i = 3'(f3); funct7b5_i = 1'(f7);
    rd_i = 5'(rd); rs1_i = 5'(rs1); rs2_i = 5'(rs2); imm_i = imm;
  endtask

  task automatic send(input int fmt, input int op, input int f3, input int f7,
                      input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    logic [31:0] w;
    int code;
    int waitc;
    waitc = 0;
    @(negedge clk_i);
    while (!req_ready_o && waitc < 10) begin
      @(negedge clk_i);
      waitc++;
    end
    chk("ready_before_req", 32'(req_ready_o), 32'd1);
    if (req_ready_o) begin
      drive(fmt, op, f3, f7, rd, rs1, rs2, imm);
      req_valid_i = 1'b1;
      model_enc(fmt, op, f3, f7, rd, rs1, rs2, imm, w, code);
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      if (code != 0) begin
        m_err = 1;
        if (m_code == 0) m_code = code;
      end else begin
        exp_addr_q.push_back(m_ptr);
        exp_data_q.push_back(w);
        m_count++;
        if (m_ptr == CAP - 1) m_full = 1;
        else m_ptr++;
      end
      @(negedge clk_i);
      chk("ready_in_check", 32'(req_ready_o), 32'd0);
      chk("we_in_check", 32'(mem_we_o), 32'd0);
      @(negedge clk_i);
      chk("we_latency", 32'(mem_we_o), 32'(code == 0));
      @(negedge clk_i);
      chk("we_one_cycle", 32'(mem_we_o), 32'd0);
      chk_state("after_req");
    end
  endtask

  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    chk_state("after_start");
  endtask

  task automatic refused(input int cycles);
    @(negedge clk_i);
    drive(0, 7'h33, 0, 0, 3, 1, 2, 32'd0);
    req_valid_i = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      chk("refused_ready", 32'(req_ready_o), 32'd0);
      chk("refused_count", 32'(count_o), 32'(m_count));
    end
    req_valid_i = 1'b0;
  endtask

  task automatic reset_mid_write();
    @(negedge clk_i);
    drive(0, 7'h33, 0, 1, 3, 1, 2, 32'd0);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(posedge clk_i);
    #1 chk("we_before_rst", 32'(mem_we_o), 32'd1);
    #1 rst_i = 1'b1;
    #1 chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int code;
    rst_i = 1'b1; start_i = 1'b0; req_valid_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
    model_reset();

    // Pin the model against hand-assembled words.
    model_enc(1, 7'h13, 0, 0, 1, 0, 0, 32'd5, w, code);  chk("pin_addi", w, 32'h00500093);
    model_enc(0, 7'h33, 0, 0, 3, 1, 2, 32'd0, w, code);  chk("pin_add",  w, 32'h002081B3);
    model_enc(0, 7'h33, 0, 1, 3, 1, 2, 32'd0, w, code);  chk("pin_sub",  w, 32'h402081B3);
    model_enc(2, 7'h23, 2, 0, 0, 1, 2, 32'd8, w, code);  chk("pin_sw",   w, 32'h0020A423);
    model_enc(3, 7'h63, 0, 0, 0, 1, 2, -32'sd4, w, code); chk("pin_beq", w, 32'hFE208EE3);
    model_enc(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000, w, code); chk("pin_lui", w, 32'h123452B7);
    model_enc(5, 7'h6F, 0, 0, 1, 0, 0, 32'd8, w, code);  chk("pin_jal",  w, 32'h008000EF);
    model_enc(1, 7'h13, 5, 1, 1, 2, 0, 32'd3, w, code);  chk("pin_srai", w, 32'h40315093);

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_we", 32'(mem_we_o), 32'd0);
    chk("reset_wdata", mem_wdata_o, 32'd0);
    chk_state("reset");

    // addi, add, sub at consecutive addresses.
    send(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
    chk("addi_wdata", mem_wdata_o, 32'h00500093);
    chk("addi_count", 32'(count_o), 32'd1);
    send(0, 7'h33, 0, 0, 3, 1, 2, 32'd0);
    send(0, 7'h33, 0, 1, 3, 1, 2, 32'd0);
    chk("sub_wdata", mem_wdata_o, 32'h402081B3);

    // S/B/U/J fill the memory, then further requests are refused.
    do_start();
    send(2, 7'h23, 2, 0, 0, 1, 2, 32'd8);
    send(3, 7'h63, 0, 0, 0, 1, 2, -32'sd4);
    send(4, 7'h37, 0, 0, 5, 0, 0, 32'h12345000);
    chk("lui_wdata", mem_wdata_o, 32'h123452B7);
    send(5, 7'h6F, 0, 0, 1, 0, 0, 32'd8);
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(req_ready_o), 32'd0);
    refused(4);
    do_start();

    // Immediate errors, then a valid word.
    send(3, 7'h63, 0, 0, 0, 1, 2, 32'd3);
`ifdef ENC_RANGE_CHECK_EN
    chk("b_misalign_err", 32'(err_o), 32'd1);
    chk("b_misalign_code", 32'(err_code_o), 32'd3);
    chk("b_misalign_ptr", 32'(mem_addr_o), 32'd0);
`else
    chk("b_misalign_noerr", 32'(err_o), 32'd0);
`endif
    send(1, 7'h13, 0, 0, 1, 0, 0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    chk("i_range_code_held", 32'(err_code_o), 32'd3);
`else
    chk("i_range_noerr", 32'(err_o), 32'd0);
`endif
    send(1, 7'h13, 5, 1, 1, 2, 0, 32'd3);
    send(1, 7'h13, 1, 0, 1, 2, 0, 32'd40);

    // Range outranks alignment; illegal format.
    do_start();
    send(3, 7'h63, 0, 0, 0, 1, 2, 32'd4097);
`ifdef ENC_RANGE_CHECK_EN
    chk("range_before_align", 32'(err_code_o), 32'd2);
`endif
    send(6, 7'h13, 0, 0, 1, 0, 0, 32'd0);
    send(7, 7'h13, 0, 0, 1, 0, 0, 32'd0);
    send(4, 7'h37, 0, 0, 5, 0, 0, 32'h00000800);
    send(5, 7'h6F, 0, 0, 1, 0, 0, -32'sd2048);

    // Reset during WRITE drops the strobe; next write lands at the base.
    do_start();
    send(1, 7'h13, 0, 0, 1, 0, 0, 32'd5);
    reset_mid_write();
    send(0, 7'h33, 0, 0, 3, 1, 2, 32'd0);
    chk("post_rst_wdata", mem_wdata_o, 32'h002081B3);
    chk("post_rst_count", 32'(count_o), 32'd1);

    @(negedge clk_i);
    chk("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes RV32I instructions from decoded fields (format, opcode, funct3, funct7 bit 30, rd/rs1/rs2, immediate) into 32-bit words. Writes each word into instruction memory at an auto-incrementing word address. Sits between the testbench/boot loader and instruction memory. It is the encoding counterpart to the control unit's decode path.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words
BASE_ADDR, 0, word address loaded into the write pointer on reset/start

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  synchronous restart: pointer <= BASE_ADDR, clears err_o/full_o/count_o
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
fmt_i  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
opcode_i  input  7  placed in bits [6:0]
funct3_i  input  3  placed in bits [14:12] (R/I/S/B)
funct7b5_i  input  1  bit 30 for R and I-shift (funct3 1/5)
rd_i  input  5  destination register
rs1_i  input  5  source 1
rs2_i  input  5  source 2
imm_i  input  32  signed immediate; byte offset for B/J; full upper value for U
mem_we_o  output  1  one-cycle write strobe
mem_addr_o  output  ADDR_WIDTH  write word address
mem_wdata_o  output  32  encoded instruction
count_o  output  ADDR_WIDTH+1  words written since reset/start
full_o  output  1  pointer exhausted
err_o  output  1  sticky error
err_code_o  output  2  0=none 1=illegal fmt 2=imm out of range 3=imm misaligned; holds the first error

Behaviour:
- Reset values: req_ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, count_o=0, full_o=0, err_o=0, err_code_o=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: req_ready_o=!full_o. On valid&ready, register all fields and go to CHECK.
  - CHECK: encode and validate. If OK go to WRITE. On error set err_o, record err_code_o only if it was 0, and return to IDLE with no write and the pointer unchanged.
  - WRITE: mem_we_o=1 for exactly one cycle with mem_addr_o=pointer. Then pointer+1, count_o+1, return to IDLE.
- Latency: accept at edge t; mem_we_o is high in cycle t+2. Throughput is 1 request per 3 cycles. req_ready_o is low in CHECK and WRITE.
- Encoding:
  - R: {0,f7b5,00000, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}. For f3 = 1 or 5 the upper 7 bits are {0,f7b5,00000} and imm must be 0..31.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Validation:
  - I/S: -2048..2047 (shift: 0..31).
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0] must be 0, otherwise misaligned.
  - R: imm ignored.
  - Range is checked before alignment: when both fail, code 2 is recorded.
- Full: after the write to address 2^ADDR_WIDTH-1, full_o=1 and the pointer does not wrap. Requests are refused until start_i or reset.
- An error does not block further requests; subsequent valid requests are still written.
- start_i has priority over any FSM activity: it aborts CHECK/WRITE with no strobe, returns to IDLE and applies the clears.
- rst_i mid-operation: immediate return to reset values; any pending write is dropped.

Optional Feature:
ENC_RANGE_CHECK_EN
- Defined: range and alignment checks as above (error codes 2/3).
- Undefined: no range/alignment checks. Immediates are truncated to their field bits and always written; only illegal-fmt errors (code 1) are possible.

Test Plan:
- I addi: fmt=1, op=0x13, f3=0, rd=1, rs1=0, imm=5 -> mem_we_o at t+2, addr 0, wdata 0x00500093, count_o=1.
- R pair: add (f7b5=0) then sub (f7b5=1) with op=0x33, rd=3, rs1=1, rs2=2 -> 0x002081B3 at addr 0, then 0x402081B3 at addr 1.
- S/B/U: sw x2,8(x1) -> 0x0020A423; beq x1,x2,-4 -> 0xFE208EE3; lui x5 with imm=0x12345000 -> 0x123452B7; consecutive addresses.
- Errors: B imm=3 -> no write, err_o=1, err_code_o=3, pointer unchanged. Then I imm=4096 -> err_code_o stays 3. Then a valid word is written to the same address. With the macro undefined, no error on either bad-immediate request.
- Full: ADDR_WIDTH=2, write 4 words -> full_o=1, req_ready_o=0, 5th request is not accepted. start_i -> full_o=0, count_o=0, next write goes to addr 0.
- Reset mid-op: assert rst_i during WRITE -> mem_we_o deasserts immediately, count_o=0, next request is written to BASE_ADDR.
